// File: rtl/lcd_cmd_sequencer.sv
// HD44780-style 4-bit LCD write sequencer: splits each byte into two timed E pulses.
// Optional power-up init sequence is built only when LCD_SEQ_INIT_EN is defined.
module lcd_cmd_sequencer #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_SU    = 2,
  parameter int T_E     = 12,
  parameter int T_NIB   = 50,
  parameter int T_SHORT = 2000,
  parameter int T_LONG  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_rs,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  // Handshake: a byte is taken on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so at most one byte is taken per IDLE visit.

  localparam int CW = 20;

  if (T_SU < 1 || T_E < 1 || T_NIB < 1 || T_SHORT < 1 || T_LONG < 1 ||
      T_PWRUP < 1 || T_INIT1 < 1 || T_INIT2 < 1 ||
      T_SU + T_E > 1048576 || T_NIB > 1048576 || T_SHORT > 1048576 ||
      T_LONG > 1048576 || T_PWRUP > 1048576 || T_INIT1 > 1048576 ||
      T_INIT2 > 1048576) begin : g_bad_timing
    $error("lcd_cmd_sequencer: timing parameters must lie in 1..2**20");
  end

  localparam logic [3:0] IDLE     = 4'd3;
  localparam logic [3:0] HI_SU    = 4'd4;
  localparam logic [3:0] HI_E     = 4'd5;
  localparam logic [3:0] GAP      = 4'd6;
  localparam logic [3:0] LO_SU    = 4'd7;
  localparam logic [3:0] LO_E     = 4'd8;
  localparam logic [3:0] CMD_WAIT = 4'd9;

  // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
  localparam logic [CW-1:0] LD_SU    = 20'(T_SU - 1);
  localparam logic [CW-1:0] LD_E     = 20'(T_E - 1);
  localparam logic [CW-1:0] LD_NIB   = 20'(T_NIB - 1);
  localparam logic [CW-1:0] LD_SHORT = 20'(T_SHORT - 1);
  localparam logic [CW-1:0] LD_LONG  = 20'(T_LONG - 1);

`ifdef LCD_SEQ_INIT_EN
  localparam logic [3:0] PWR_WAIT  = 4'd0;
  localparam logic [3:0] INIT_NIB  = 4'd1;
  localparam logic [3:0] INIT_WAIT = 4'd2;

  localparam logic [CW-1:0] LD_PWRUP  = 20'(T_PWRUP - 1);
  localparam logic [CW-1:0] LD_INIT1  = 20'(T_INIT1 - 1);
  localparam logic [CW-1:0] LD_INIT2  = 20'(T_INIT2 - 1);
  // INIT_NIB covers setup and E-high in one state; E rises when T_E cycles remain.
  localparam logic [CW-1:0] LD_INIB   = 20'(T_SU + T_E - 1);
  localparam logic [CW-1:0] INIB_RISE = 20'(T_E);

  logic [1:0]    step;
  logic [CW-1:0] init_wait_ld;

  always_comb begin
    init_wait_ld = LD_SHORT;
    case (step)
      2'd0:    init_wait_ld = LD_INIT1;
      2'd1:    init_wait_ld = LD_INIT2;
      default: init_wait_ld = LD_SHORT;
    endcase
  end
`endif

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    cap_data;
  logic          cap_rs;
  logic          is_long;

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  assign is_long = !cap_rs && (cap_data[7:2] == 6'd0) && (cap_data[1:0] != 2'd0);
  assign lcd_rw  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef LCD_SEQ_INIT_EN
      state <= PWR_WAIT;
      cnt   <= LD_PWRUP;
      step  <= 2'd0;
`else
      state <= IDLE;
      cnt   <= '0;
`endif
      cap_data  <= 8'h00;
      cap_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= 4'h0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
`ifdef LCD_SEQ_INIT_EN
        PWR_WAIT: begin
          if (cnt == '0) begin
            state  <= INIT_NIB;
            cnt    <= LD_INIB;
            lcd_rs <= 1'b0;
            lcd_d  <= 4'h3;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        INIT_NIB: begin
          if (cnt == '0) begin
            state <= INIT_WAIT;
            cnt   <= init_wait_ld;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == INIB_RISE) lcd_e <= 1'b1;
          end
        end
        INIT_WAIT: begin
          if (cnt == '0) begin
            if (step == 2'd3) begin
              state     <= IDLE;
              cnt       <= '0;
              lcd_d     <= 4'h0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end else begin
              step  <= step + 2'd1;
              state <= INIT_NIB;
              cnt   <= LD_INIB;
              lcd_d <= (step == 2'd2) ? 4'h2 : 4'h3;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        IDLE: begin
          lcd_e <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cap_data  <= cmd_data;
            cap_rs    <= cmd_rs;
            lcd_rs    <= cmd_rs;
            lcd_d     <= cmd_data[7:4];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= HI_SU;
            cnt       <= LD_SU;
          end else begin
            lcd_rs    <= 1'b0;
            lcd_d     <= 4'h0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end
        end
        HI_SU: begin
          if (cnt == '0) begin
            state <= HI_E;
            cnt   <= LD_E;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI_E: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= LD_NIB;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= LO_SU;
            cnt   <= LD_SU;
            lcd_d <= cap_data[3:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LO_SU: begin
          if (cnt == '0) begin
            state <= LO_E;
            cnt   <= LD_E;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LO_E: begin
          if (cnt == '0) begin
            state <= CMD_WAIT;
            cnt   <= is_long ? LD_LONG : LD_SHORT;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CMD_WAIT: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cnt       <= '0;
            lcd_rs    <= 1'b0;
            lcd_d     <= 4'h0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          lcd_e     <= 1'b0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
LCD_CMD_SEQUENCER -- requirements
Module: lcd_cmd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- T_PWRUP, 750000, power-up wait cycles (15 ms @ 50 MHz)
- T_INIT1, 205000, wait after first init nibble
- T_INIT2, 5000, wait after second init nibble
- T_SU, 2, RS/data setup cycles before E rise
- T_E, 12, E high cycles
- T_NIB, 50, gap cycles between upper and lower nibble
- T_SHORT, 2000, post-command wait, normal commands
- T_LONG, 82000, post-command wait, clear/home
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- cmd_valid, in, 1, command offered
- cmd_ready, out, 1, sequencer can accept
- cmd_data, in, 8, byte to write
- cmd_rs, in, 1, 0 = instruction, 1 = data
- busy, out, 1, high whenever not IDLE
- init_done, out, 1, init sequence complete
- lcd_e, out, 1, LCD enable
- lcd_rs, out, 1, LCD register select
- lcd_rw, out, 1, LCD read/write, constant 0
- lcd_d, out, 4, LCD data nibble
REQ-003 There SHALL be one clock; reset SHALL be synchronous and active-high, sampled on the rising edge of clk.

Function
REQ-004 All outputs SHALL be registered; a single 20-bit down-counter SHALL time every state.
REQ-005 FSM states SHALL be: PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, HI_SU, HI_E, GAP, LO_SU, LO_E, CMD_WAIT.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a transfer SHALL occur on an edge where cmd_valid && cmd_ready.
REQ-007 On a transfer, cmd_data and cmd_rs SHALL be captured; the FSM SHALL enter HI_SU and cmd_ready SHALL be 0 from the next cycle.
REQ-008 HI_SU SHALL last T_SU cycles with lcd_rs = captured rs, lcd_d = data[7:4], and lcd_e = 0.
REQ-009 HI_E SHALL last T_E cycles with lcd_e = 1; GAP SHALL then last T_NIB cycles with lcd_e = 0 and lcd_d held.
REQ-010 LO_SU and LO_E SHALL repeat REQ-008 and REQ-009 using data[3:0].
REQ-011 CMD_WAIT SHALL last T_LONG when rs = 0, data[7:2] = 0 and data[1:0] != 0 (clear/home); otherwise it SHALL last T_SHORT. The FSM SHALL then return to IDLE.
REQ-012 cmd_ready SHALL reassert exactly 2*T_SU + 2*T_E + T_NIB + wait cycles after the transfer edge, where wait is the CMD_WAIT duration from REQ-011 (2078 cycles for a normal command at defaults).
REQ-013 In IDLE, lcd_e SHALL be 0 and lcd_d and lcd_rs SHALL be 0; busy SHALL equal !cmd_ready.
REQ-014 cmd_valid SHALL be ignored in every state other than IDLE, and no command SHALL be queued.
REQ-015 Init sequence (REQ-019): PWR_WAIT lasts T_PWRUP cycles, then four nibble writes with rs = 0. Each nibble write is T_SU setup, then T_E with E high, then INIT_WAIT.
REQ-016 The four init nibbles SHALL be, in order: 0x3 followed by a T_INIT1 wait, 0x3 followed by a T_INIT2 wait, 0x3 followed by a T_SHORT wait, and 0x2 followed by a T_SHORT wait. A 2-bit step index SHALL track position in the sequence.
REQ-017 init_done SHALL rise on the same edge as the FSM enters IDLE from INIT_WAIT step 3, and SHALL stay 1 until reset.

Reset
REQ-018 While reset is asserted: lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_d = 0, cmd_ready = 0, init_done = 0, busy = 1, and the counter SHALL be loaded for the entry state. A reset asserted mid-command or mid-init SHALL abort the operation at that edge with no completion pulse.

Configuration
REQ-019 Macro LCD_SEQ_INIT_EN:
- Defined: reset SHALL enter PWR_WAIT and run REQ-015 to REQ-017.
- Undefined: the init states and T_PWRUP/T_INIT1/T_INIT2 logic SHALL be omitted, and reset SHALL enter IDLE. init_done and cmd_ready SHALL then be 1 from the first edge after reset deasserts.

Verification
REQ-020 Benches SHALL cover these directed scenarios:
- Macro defined, release reset -> lcd_e first rises 750000 + 2 cycles later with lcd_d = 0x3; pulses 0x3, 0x3, 0x3, 0x2 are seen; init_done = 1 after the final 2000-cycle wait.
- After init, write 0x48 with rs = 1 -> lcd_d = 0x4 during the first E pulse and 0x8 during the second, 12 cycles each with lcd_rs = 1; cmd_ready returns 2078 cycles after transfer.
- Write 0x01 with rs = 0 -> cmd_ready returns 80078 + 2000 = 82078 cycles after transfer.
- cmd_valid held high during init and during a command -> no extra E pulses; exactly one transfer per IDLE visit.
- Reset asserted in the middle of the HI_E state -> lcd_e = 0 at the next edge, and the init sequence restarts from PWR_WAIT.
- Macro undefined -> cmd_ready = 1 on the first edge after reset, and the first command produces correct nibble timing.
